// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and bridge state encoding
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } bridge_state_e;

    // SLVERR and DECERR are reported to the core as a single error flag.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-outstanding core request port to AXI4-Lite initiator
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   i_req_* / o_req_ready       core request (valid/ready, we, addr, wdata, wstrb)
//   o_rsp_*                     one-cycle completion pulse with read data and error flag
//   o_axi_aw* / i_axi_awready   write address channel
//   o_axi_w*  / i_axi_wready    write data channel
//   i_axi_b*  / o_axi_bready    write response channel
//   o_axi_ar* / i_axi_arready   read address channel
//   i_axi_r*  / o_axi_rready    read data channel
// Every output comes straight from a flop.
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,

    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,

    output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
    output logic                    o_axi_awvalid,
    input  logic                    i_axi_awready,

    output logic [DATA_WIDTH-1:0]   o_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
    output logic                    o_axi_wvalid,
    input  logic                    i_axi_wready,

    input  logic [1:0]              i_axi_bresp,
    input  logic                    i_axi_bvalid,
    output logic                    o_axi_bready,

    output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
    output logic                    o_axi_arvalid,
    input  logic                    i_axi_arready,

    input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
    input  logic [1:0]              i_axi_rresp,
    input  logic                    i_axi_rvalid,
    output logic                    o_axi_rready
);

    bridge_state_e             state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready_q guards the first cycle after reset, when the
                // state is already IDLE but the core has not seen ready yet.
                if (req_ready_q && i_req_valid) begin
                    if (i_req_we) begin
                        awaddr_d  = i_req_addr;
                        wdata_d   = i_req_wdata;
                        wstrb_d   = i_req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = i_req_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently, in either order or together.
                if (awvalid_q && i_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && i_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (i_axi_bvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(i_axi_bresp);
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (i_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (i_axi_rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = i_axi_rdata;
                    rsp_err_d   = resp_is_err(i_axi_rresp);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decoded from the next state so ready/bready/rready are registered
        // yet line up with the state they describe; ready returns in the
        // same cycle as the response pulse.
        req_ready_d = (state_d == ST_IDLE);
        bready_d    = (state_d == ST_WR_RESP);
        rready_d    = (state_d == ST_RD_RESP);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_axi_awaddr  = awaddr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_araddr  = araddr_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb/tb_axi_lite_master_bridge.sv - self-checking bench for axi_lite_master_bridge
module tb_axi_lite_master_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        i_req_valid, i_req_we;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [3:0]  i_req_wstrb;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [31:0] o_axi_awaddr, o_axi_wdata, o_axi_araddr, i_axi_rdata;
    logic [3:0]  o_axi_wstrb;
    logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
    logic [1:0]  i_axi_bresp, i_axi_rresp;
    logic        i_axi_bvalid, o_axi_bready, o_axi_arvalid, i_axi_arready;
    logic        i_axi_rvalid, o_axi_rready;

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rvalid(i_axi_rvalid),
        .o_axi_rready(o_axi_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave configuration and state
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] mem [logic [31:0]];
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_got, w_got, ar_got, b_hs_pend, r_hs_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    // Transaction-level model of the bridge
    bit          m_ready_ok, m_busy, m_we, m_aw_pend, m_w_pend, m_ar_pend, m_pulse, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    // Event records used by the directed checks
    int          cyc = 0;
    int          acc_q[$];
    int          pulse_q[$];
    bit          perr_q[$];
    logic [31:0] prdata_q[$];
    int          aw_hs_cyc, w_hs_cyc, b_hs_count;

    task automatic slave_clear();
        i_axi_awready = 0; i_axi_wready = 0; i_axi_arready = 0;
        i_axi_bvalid = 0; i_axi_bresp = 0; i_axi_rvalid = 0; i_axi_rresp = 0; i_axi_rdata = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs_pend = 0; r_hs_pend = 0;
    endtask

    task automatic model_clear();
        m_ready_ok = 0; m_busy = 0; m_we = 0; m_aw_pend = 0; m_w_pend = 0; m_ar_pend = 0;
        m_pulse = 0; m_err = 0; m_rdata = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    endtask

    task automatic compare();
        check("req_ready", o_req_ready, m_ready_ok && !m_busy);
        check("rsp_valid", o_rsp_valid, m_pulse);
        if (m_pulse) check("rsp_err", o_rsp_err, m_err);
        check("rsp_rdata", o_rsp_rdata, m_rdata);
        check("awvalid", o_axi_awvalid, m_aw_pend);
        check("wvalid", o_axi_wvalid, m_w_pend);
        check("arvalid", o_axi_arvalid, m_ar_pend);
        check("bready", o_axi_bready, m_busy && m_we && !m_aw_pend && !m_w_pend);
        check("rready", o_axi_rready, m_busy && !m_we && !m_ar_pend);
        if (m_aw_pend) check("awaddr", o_axi_awaddr, m_addr);
        if (m_w_pend) begin
            check("wdata", o_axi_wdata, m_wdata);
            check("wstrb", o_axi_wstrb, m_wstrb);
        end
        if (m_ar_pend) check("araddr", o_axi_araddr, m_addr);
    endtask

    task automatic slave_drive();
        logic [31:0] tmp;
        if (b_hs_pend) begin i_axi_bvalid = 0; b_hs_pend = 0; end
        if (!i_axi_bvalid && aw_got && w_got) begin
            if (b_wait >= b_delay) begin
                tmp = mem.exists(s_awaddr) ? mem[s_awaddr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) tmp[8*b +: 8] = s_wdata[8*b +: 8];
                mem[s_awaddr] = tmp;
                i_axi_bvalid = 1; i_axi_bresp = bresp_cfg;
                aw_got = 0; w_got = 0; b_wait = 0;
            end else b_wait++;
        end
        if (i_axi_bvalid && o_axi_bready) b_hs_pend = 1;

        i_axi_awready = 0;
        if (o_axi_awvalid && !aw_got) begin
            if (aw_wait >= aw_delay) begin
                i_axi_awready = 1; aw_got = 1; s_awaddr = o_axi_awaddr; aw_wait = 0;
            end else aw_wait++;
        end
        i_axi_wready = 0;
        if (o_axi_wvalid && !w_got) begin
            if (w_wait >= w_delay) begin
                i_axi_wready = 1; w_got = 1; s_wdata = o_axi_wdata; s_wstrb = o_axi_wstrb; w_wait = 0;
            end else w_wait++;
        end

        if (r_hs_pend) begin i_axi_rvalid = 0; r_hs_pend = 0; end
        if (!i_axi_rvalid && ar_got) begin
            if (r_wait >= r_delay) begin
                i_axi_rvalid = 1; i_axi_rresp = rresp_cfg;
                i_axi_rdata = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
                ar_got = 0; r_wait = 0;
            end else r_wait++;
        end
        if (i_axi_rvalid && o_axi_rready) r_hs_pend = 1;

        i_axi_arready = 0;
        if (o_axi_arvalid && !ar_got) begin
            if (ar_wait >= ar_delay) begin
                i_axi_arready = 1; ar_got = 1; s_araddr = o_axi_araddr; ar_wait = 0;
            end else ar_wait++;
        end
    endtask

    // Advance the model by the events that complete at the coming rising edge.
    task automatic model_step();
        m_pulse = 0;
        if (m_busy) begin
            if (m_we) begin
                if (m_aw_pend || m_w_pend) begin
                    if (m_aw_pend && i_axi_awready) begin m_aw_pend = 0; aw_hs_cyc = cyc; end
                    if (m_w_pend && i_axi_wready) begin m_w_pend = 0; w_hs_cyc = cyc; end
                end else if (i_axi_bvalid) begin
                    m_pulse = 1; m_busy = 0; b_hs_count++;
                    m_err = (i_axi_bresp == 2'b10) || (i_axi_bresp == 2'b11);
                end
            end else begin
                if (m_ar_pend) begin
                    if (i_axi_arready) m_ar_pend = 0;
                end else if (i_axi_rvalid) begin
                    m_pulse = 1; m_busy = 0; m_rdata = i_axi_rdata;
                    m_err = (i_axi_rresp == 2'b10) || (i_axi_rresp == 2'b11);
                end
            end
            if (m_pulse) begin
                pulse_q.push_back(cyc + 1); perr_q.push_back(m_err); prdata_q.push_back(m_rdata);
            end
        end else if (m_ready_ok && i_req_valid) begin
            m_busy = 1; m_we = i_req_we; m_addr = i_req_addr;
            m_wdata = i_req_wdata; m_wstrb = i_req_wstrb;
            m_aw_pend = i_req_we; m_w_pend = i_req_we; m_ar_pend = !i_req_we;
            acc_q.push_back(cyc);
        end
        m_ready_ok = 1;
    endtask

    initial begin
        slave_clear();
        model_clear();
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                model_clear();
                slave_clear();
            end else begin
                compare();
                slave_drive();
                model_step();
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic clear_records();
        acc_q.delete(); pulse_q.delete(); perr_q.delete(); prdata_q.delete(); b_hs_count = 0;
    endtask

    // Presents a request and returns just after the edge that accepted it.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        int n;
        i_req_valid = 1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_req_wstrb = strb;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_req_ready && n < 100);
        check("req_accepted", o_req_ready, 1'b1);
        sync();
        i_req_valid = 0;
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while (pulse_q.size() < n && k < 200) begin @(negedge clk); k++; end
        check("pulse_count", pulse_q.size(), n);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        resetn = 0; i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_wdata = 0; i_req_wstrb = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        mem[32'h1000_0008] = 32'hDEAD_BEEF;
        mem[32'h1000_0010] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        check("rst_req_ready", o_req_ready, 0);
        check("rst_awvalid", o_axi_awvalid, 0);
        check("rst_wvalid", o_axi_wvalid, 0);
        check("rst_arvalid", o_axi_arvalid, 0);
        check("rst_bready", o_axi_bready, 0);
        check("rst_rready", o_axi_rready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_rsp_rdata", o_rsp_rdata, 0);
        check("rst_awaddr", o_axi_awaddr, 0);
        check("rst_wdata", o_axi_wdata, 0);
        check("rst_wstrb", o_axi_wstrb, 0);
        check("rst_araddr", o_axi_araddr, 0);
        sync(); resetn = 1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", o_req_ready, 1);

        // Zero-wait write
        sync(); clear_records();
        issue(1, 32'h1000_0004, 32'hA5A5_0001, 4'hF);
        wait_pulses(1);
        check("wr_latency", pulse_q[0] - acc_q[0], 3);
        check("wr_aw_cycle", aw_hs_cyc - acc_q[0], 1);
        check("wr_w_cycle", w_hs_cyc - acc_q[0], 1);
        check("wr_err", perr_q[0], 0);
        check("wr_mem", mem[32'h1000_0004], 32'hA5A5_0001);

        // Split write, AW first, partial strobe
        aw_delay = 1; w_delay = 4;
        sync(); clear_records();
        issue(1, 32'h1000_0010, 32'hAABB_CCDD, 4'h5);
        wait_pulses(1);
        check("split1_aw_cycle", aw_hs_cyc - acc_q[0], 2);
        check("split1_w_cycle", w_hs_cyc - acc_q[0], 5);
        check("split1_latency", pulse_q[0] - acc_q[0], 7);
        check("split1_b_count", b_hs_count, 1);
        check("split1_mem", mem[32'h1000_0010], 32'h11BB_33DD);

        // Split write, W first
        aw_delay = 4; w_delay = 1;
        sync(); clear_records();
        issue(1, 32'h1000_0014, 32'h0BAD_F00D, 4'hF);
        wait_pulses(1);
        check("split2_aw_cycle", aw_hs_cyc - acc_q[0], 5);
        check("split2_w_cycle", w_hs_cyc - acc_q[0], 2);
        check("split2_latency", pulse_q[0] - acc_q[0], 7);
        check("split2_b_count", b_hs_count, 1);
        check("split2_mem", mem[32'h1000_0014], 32'h0BAD_F00D);
        aw_delay = 0; w_delay = 0;

        // Read with late rvalid
        r_delay = 3;
        sync(); clear_records();
        issue(0, 32'h1000_0008, 32'h0, 4'h0);
        wait_pulses(1);
        check("rd_latency", pulse_q[0] - acc_q[0], 6);
        check("rd_rdata", prdata_q[0], 32'hDEAD_BEEF);
        check("rd_err", perr_q[0], 0);
        check("rd_rdata_hold", o_rsp_rdata, 32'hDEAD_BEEF);
        r_delay = 0;

        // Error responses
        bresp_cfg = 2'b10;
        sync(); clear_records();
        issue(1, 32'h2000_0000, 32'h0000_0055, 4'hF);
        wait_pulses(1);
        check("slverr_wr_err", perr_q[0], 1);
        check("wr_keeps_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
        bresp_cfg = 2'b00; rresp_cfg = 2'b11;
        sync(); clear_records();
        issue(0, 32'h2000_0004, 32'h0, 4'h0);
        wait_pulses(1);
        check("decerr_rd_err", perr_q[0], 1);
        rresp_cfg = 2'b00;
        sync(); clear_records();
        issue(0, 32'h1000_0004, 32'h0, 4'h0);
        wait_pulses(1);
        check("okay_rd_err", perr_q[0], 0);
        check("okay_rd_rdata", prdata_q[0], 32'hA5A5_0001);

        // Back-to-back write then read
        sync(); clear_records();
        issue(1, 32'h1000_0018, 32'h600D_CAFE, 4'hF);
        issue(0, 32'h1000_0018, 32'h0, 4'h0);
        wait_pulses(2);
        check("b2b_second_accept", acc_q[1] - acc_q[0], 3);
        check("b2b_accept_on_pulse", acc_q[1], pulse_q[0]);
        check("b2b_total", pulse_q[1] - acc_q[0], 6);
        check("b2b_rdata", prdata_q[1], 32'h600D_CAFE);

        // Reset in the middle of a write address phase
        aw_delay = 6; w_delay = 6;
        sync(); clear_records();
        issue(1, 32'h1000_0020, 32'h1234_5678, 4'hF);
        @(negedge clk);
        check("mid_awvalid", o_axi_awvalid, 1);
        #2 resetn = 0;
        #1;
        check("mid_rst_awvalid", o_axi_awvalid, 0);
        check("mid_rst_wvalid", o_axi_wvalid, 0);
        check("mid_rst_arvalid", o_axi_arvalid, 0);
        check("mid_rst_bready", o_axi_bready, 0);
        check("mid_rst_rsp_valid", o_rsp_valid, 0);
        repeat (2) @(negedge clk);
        sync(); resetn = 1;
        aw_delay = 0; w_delay = 0;
        repeat (3) @(negedge clk);
        check("mid_rst_ready", o_req_ready, 1);
        check("mid_rst_no_pulse", pulse_q.size(), 0);
        sync(); clear_records();
        issue(0, 32'h1000_0004, 32'h0, 4'h0);
        wait_pulses(1);
        check("post_rst_rdata", prdata_q[0], 32'hA5A5_0001);
        check("post_rst_latency", pulse_q[0] - acc_q[0], 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- AXI4-Lite initiator that converts a simple single-outstanding core request port (CPU/DMA side) into AXI-Lite write and read transactions toward peripheral slaves such as the SPI register interface.
- One transaction in flight at a time; independent AW/W handshake tracking; completion returned as a one-cycle response pulse with read data and error flag.

Parameters:
- ADDR_WIDTH, 32, address width of request and AXI address channels
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  bridge idle, request accepted when valid&&ready
- i_req_we  in  1  1=write, 0=read
- i_req_addr  in  ADDR_WIDTH  byte address
- i_req_wdata  in  DATA_WIDTH  write data
- i_req_wstrb  in  DATA_WIDTH/8  byte enables (write only)
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  DATA_WIDTH  read data (valid with o_rsp_valid on reads)
- o_rsp_err  out  1  BRESP/RRESP was SLVERR or DECERR
- o_axi_awaddr  out  ADDR_WIDTH;  o_axi_awvalid  out  1;  i_axi_awready  in  1
- o_axi_wdata  out  DATA_WIDTH;  o_axi_wstrb  out  DATA_WIDTH/8;  o_axi_wvalid  out  1;  i_axi_wready  in  1
- i_axi_bresp  in  2;  i_axi_bvalid  in  1;  o_axi_bready  out  1
- o_axi_araddr  out  ADDR_WIDTH;  o_axi_arvalid  out  1;  i_axi_arready  in  1
- i_axi_rdata  in  DATA_WIDTH;  i_axi_rresp  in  2;  i_axi_rvalid  in  1;  o_axi_rready  out  1

Behaviour:
- Reset (async, resetn=0): state IDLE, all valid/ready outputs 0, addr/data/strb/rdata outputs 0, o_rsp_err 0. o_req_ready goes 1 after reset deasserts.
- All outputs registered or decoded from registered state only; no output depends combinationally on an AXI ready/valid input.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: o_req_ready=1. On i_req_valid: latch addr/wdata/wstrb into AXI output regs. we=1 goes to WR_REQ with awvalid=wvalid=1 next cycle; we=0 goes to RD_REQ with arvalid=1 next cycle.
- WR_REQ: awvalid and wvalid held independently. Each drops the cycle after its own handshake (valid&&ready); aw_done/w_done flags record completion. Both handshakes may occur in the same cycle or in either order. Go to WR_RESP once both are done, including both done in the same cycle.
- WR_RESP: bready=1. On bvalid: o_rsp_valid=1 next cycle, o_rsp_err=bresp[1], state to IDLE.
- RD_REQ: arvalid held until arready, then RD_RESP.
- RD_RESP: rready=1. On rvalid: o_rsp_rdata=rdata, o_rsp_err=rresp[1], o_rsp_valid=1 next cycle, state to IDLE.
- AXI rules: valid never withdrawn before handshake. addr/data/strb stable while valid. bready/rready are 1 only in the response states.
- Minimum latency, zero-wait slave: write = accept cycle 0, AW/W handshake cycle 1, B handshake cycle 2, rsp pulse cycle 3. Read has the same 3-cycle latency.
- o_rsp_valid is exactly 1 cycle. o_req_ready returns to 1 in the same cycle as the pulse, so back-to-back requests lose no extra cycle.
- o_rsp_rdata holds its last value between reads. o_rsp_rdata is not updated on writes.
- Requests are ignored while o_req_ready=0. The core must hold its request until accepted.
- Reset mid-transaction: all valids drop immediately (async). Any pending slave response is not acknowledged. No o_rsp_valid is produced.

Decomposition:
- Shared package axi_lite_pkg: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants (2'b00..2'b11) and bridge state encodings.
- Single flat module. No sub-module is needed.

Test Plan:
- Write, zero-wait slave: req we=1 addr=0x1000_0004 wdata=0xA5A5_0001 wstrb=0xF -> AW/W valid cycle 1, bready cycle 2, o_rsp_valid cycle 3, err=0; slave memory holds 0xA5A5_0001.
- Split write handshake: awready 1 cycle after valid, wready 4 cycles after -> awvalid drops after its handshake, wvalid stays until its own, single B handshake, one rsp pulse. Repeat with wready before awready.
- Read: addr=0x1000_0008, slave returns rdata=0xDEADBEEF with rvalid 3 cycles late -> rready held high, o_rsp_rdata=0xDEADBEEF, err=0, pulse width 1.
- Error: bresp=2'b10 on a write, then rresp=2'b11 on a read -> o_rsp_err=1 on both pulses. A following OKAY read gives err=0.
- Back-to-back: write then read issued on consecutive ready cycles against a zero-wait slave -> second request accepted in the same cycle as the first pulse; total 6 cycles.
- Reset while in WR_REQ with awvalid=1 -> all AXI valids 0 immediately, no rsp pulse, o_req_ready=1 after release; next read completes normally.
